// File: rtl/jtflane_pcm_arb.sv
// jtflane_pcm_arb: four PCM channels share one ROM slot through tagged one-entry buffers.
// Define JTFLANE_PCMARB_PREFETCH_EN to add a tag+1 prefetch buffer per channel.
`default_nettype none

module jtflane_pcm_arb #(
   parameter int             AW    = 19,
   parameter int             SAW   = 19,
   parameter int             DW    = 8,
   parameter logic [SAW-1:0] OFFS0 = '0,
   parameter logic [SAW-1:0] OFFS1 = '0,
   parameter logic [SAW-1:0] OFFS2 = '0,
   parameter logic [SAW-1:0] OFFS3 = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [3:0]      ch_cs,
   input  logic [4*AW-1:0] ch_addr,
   output logic [3:0]      ch_ok,
   output logic [4*DW-1:0] ch_dout,
   output logic            slot_cs,
   output logic [SAW-1:0]  slot_addr,
   input  logic            slot_ok,
   input  logic [DW-1:0]   slot_dout,
   output logic [1:0]      grant
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t         state_q;
   logic [AW-1:0]  tag_q  [4];
   logic [DW-1:0]  data_q [4];
   logic [3:0]     valid_q;
   logic [1:0]     rr_q;
   logic [1:0]     grant_q;
   logic [AW-1:0]  ftag_q;
   logic           slot_cs_q;
   logic [SAW-1:0] slot_addr_q;

   logic [AW-1:0]  addr_w [4];
   logic [SAW-1:0] offs_w [4];
   logic [3:0]     hit;
   logic [3:0]     miss;
   logic [1:0]     pick_d;
   logic [1:0]     fetch_ch_d;
   logic [AW-1:0]  fetch_tag_d;
   logic           start_d;

   assign offs_w[0] = OFFS0;
   assign offs_w[1] = OFFS1;
   assign offs_w[2] = OFFS2;
   assign offs_w[3] = OFFS3;

   for (genvar n = 0; n < 4; n++) begin : g_ch
      assign addr_w[n]           = ch_addr[n*AW +: AW];
      assign hit[n]              = ch_cs[n] & valid_q[n] & (tag_q[n] == addr_w[n]);
      assign ch_dout[n*DW +: DW] = data_q[n];
   end

   assign miss      = ch_cs & ~hit;
   assign ch_ok     = hit;
   assign slot_cs   = slot_cs_q;
   assign slot_addr = slot_addr_q;
   assign grant     = grant_q;

   // Scan rr+4 down to rr+1 so the nearest channel after rr wins.
   always_comb begin
      pick_d = rr_q;
      for (int k = 4; k >= 1; k--) begin
         if (miss[rr_q + 2'(k)]) pick_d = rr_q + 2'(k);
      end
   end

`ifdef JTFLANE_PCMARB_PREFETCH_EN
   logic [AW-1:0] pftag_q  [4];
   logic [DW-1:0] pfdata_q [4];
   logic [3:0]    pfvalid_q;
   logic          pf_q;
   logic [3:0]    pfhit;
   logic [AW-1:0] pfnext_d;
   logic          pf_want_d;
   logic          copy_d;

   for (genvar n = 0; n < 4; n++) begin : g_pf
      assign pfhit[n] = pfvalid_q[n] & (pftag_q[n] == addr_w[n]);
   end

   assign pfnext_d  = tag_q[rr_q] + AW'(1);
   assign pf_want_d = valid_q[rr_q] & ~(pfvalid_q[rr_q] & (pftag_q[rr_q] == pfnext_d));
   assign copy_d    = (|miss) & pfhit[pick_d];

   always_comb begin
      fetch_ch_d  = (|miss) ? pick_d : rr_q;
      fetch_tag_d = (|miss) ? addr_w[pick_d] : pfnext_d;
      start_d     = (|miss) ? ~copy_d : pf_want_d;
   end
`else
   always_comb begin
      fetch_ch_d  = pick_d;
      fetch_tag_d = addr_w[pick_d];
      start_d     = |miss;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         valid_q     <= '0;
         rr_q        <= 2'd3;
         grant_q     <= 2'd0;
         ftag_q      <= '0;
         slot_cs_q   <= 1'b0;
         slot_addr_q <= '0;
         for (int n = 0; n < 4; n++) begin
            tag_q[n]  <= '0;
            data_q[n] <= '0;
         end
`ifdef JTFLANE_PCMARB_PREFETCH_EN
         pfvalid_q <= '0;
         pf_q      <= 1'b0;
         for (int n = 0; n < 4; n++) begin
            pftag_q[n]  <= '0;
            pfdata_q[n] <= '0;
         end
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
`ifdef JTFLANE_PCMARB_PREFETCH_EN
               if (copy_d) begin
                  data_q[pick_d]  <= pfdata_q[pick_d];
                  tag_q[pick_d]   <= pftag_q[pick_d];
                  valid_q[pick_d] <= 1'b1;
               end
               pf_q <= ~(|miss);
`endif
               if (start_d) begin
                  grant_q     <= fetch_ch_d;
                  ftag_q      <= fetch_tag_d;
                  slot_addr_q <= SAW'(fetch_tag_d) + offs_w[fetch_ch_d];
                  slot_cs_q   <= 1'b1;
                  state_q     <= ST_ISSUE;
               end
            end
            // A leftover ok from the previous access may still be high here.
            ST_ISSUE: state_q <= ST_WAIT;
            ST_WAIT: begin
               if (slot_ok) begin
`ifdef JTFLANE_PCMARB_PREFETCH_EN
                  if (pf_q) begin
                     pfdata_q[grant_q]  <= slot_dout;
                     pftag_q[grant_q]   <= ftag_q;
                     pfvalid_q[grant_q] <= 1'b1;
                  end else
`endif
                  begin
                     data_q[grant_q]  <= slot_dout;
                     tag_q[grant_q]   <= ftag_q;
                     valid_q[grant_q] <= 1'b1;
                     rr_q             <= grant_q;
                  end
                  slot_cs_q <= 1'b0;
                  state_q   <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/jtflane_pcm_arb.md
# jtflane_pcm_arb

Four-requester scheduler that shares one 8-bit SDRAM ROM slot among the four PCM sample channels of the Fast Lane core (two channels in the PCM0 region, two in PCM1). Each channel gets a one-entry tagged data buffer and behaves like a private ROM port. The arbiter serves outstanding misses round-robin and drives a single `jtframe_rom` slot, which frees the other slots for GFX and main CPU use. It sits between `jtflane_main` (PCM address/cs outputs) and `jtframe_rom`, in the 24 MHz domain.

## Interface
Parameters:
- `AW`, 19, channel address width (narrower channel buses are zero-extended at the instance)
- `SAW`, 19, slot address width
- `DW`, 8, data width
- `OFFS0`..`OFFS3`, 0, per-channel byte offset added to the channel address (slot region base)

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  24 MHz clock
- `rst_n`  in  1  asynchronous active-low reset
- `ch_cs`  in  4  per-channel read request, bit n = channel n
- `ch_addr`  in  4*AW  channel addresses, channel n at [n*AW +: AW]
- `ch_ok`  out  4  channel data valid for its current address
- `ch_dout`  out  4*DW  channel data, channel n at [n*DW +: DW]
- `slot_cs`  out  1  ROM slot request
- `slot_addr`  out  SAW  ROM slot address
- `slot_ok`  in  1  ROM slot data valid
- `slot_dout`  in  DW  ROM slot data
- `grant`  out  2  channel currently being fetched; debug only

## Operation
- Per channel: `tag[n]` (AW), `data[n]` (DW), `valid[n]`.
- Hit: `ch_ok[n] = ch_cs[n] & valid[n] & (tag[n]==ch_addr[n])`. This is combinational, so it drops in the same cycle the address changes. `ch_dout[n] = data[n]`, registered.
- Miss: `ch_cs[n] & ~hit[n]`.
- FSM states:
  - IDLE: if any miss exists, pick the first missing channel in order `rr+1, rr+2, rr+3, rr` (mod 4). Latch `grant`, `ftag = ch_addr[grant]`, and `slot_addr = ftag + OFFSn` (truncated to SAW bits, wrap-around). Set `slot_cs=1`, then go to ISSUE.
  - ISSUE: one cycle. `slot_ok` is ignored here, because a stale `ok` from the previous address can still be present. Go to WAIT.
  - WAIT: hold `slot_cs`/`slot_addr` until `slot_ok=1`. On that cycle, write `data[grant]=slot_dout`, `tag[grant]=ftag`, `valid[grant]=1`, and `rr=grant`. Drop `slot_cs` on the next edge and return to IDLE.
- There is no timeout. WAIT holds until `slot_ok`.
- Boundary cases:
  - Address changes during that channel's own fetch: the fetch completes with the old `ftag`, the tag mismatches, the miss persists, and the channel is re-queued at its next round-robin turn.
  - `ch_cs` drops mid-fetch: the fetch completes and the data is stored. No abort.
  - Simultaneous misses on all four channels are served as 4 fetches in rotation, with no channel served twice before the others.
  - Slot completion and a new miss on the same edge: the new miss is considered in the following IDLE cycle.

## Timing
- Reset values: `slot_cs=0`, `slot_addr=0`, `ch_ok=0`, `ch_dout=0`, `grant=0`, all `valid=0`, `rr=3` (so channel 0 is first), FSM=IDLE. Reset asserted mid-fetch abandons the fetch immediately.
- Miss latency: the miss is visible in IDLE at cycle 0, `slot_cs` rises at cycle 1, WAIT begins at cycle 2. If `slot_ok` arrives at cycle k≥2, `ch_ok` rises at cycle k+1.
- Minimum turnaround between fetches: 1 IDLE cycle.

## Configuration
- `JTFLANE_PCMARB_PREFETCH_EN` defined:
  - Each channel gets a second buffer `pftag/pfdata/pfvalid`.
  - In IDLE with no misses, the arbiter fetches `tag[rr]+1` (AW-bit wrap) into channel rr's prefetch buffer, unless that buffer already holds that tag.
  - When a channel misses but `ch_addr==pftag[n]` and `pfvalid[n]`, the IDLE cycle copies the prefetch buffer to the main buffer with no slot access. `ch_ok` rises the next cycle.
  - A prefetch in flight is not aborted: misses wait for it to finish.
- Undefined: no prefetch logic. Every miss costs a slot fetch.

## Test plan
- Reset then idle: `ch_cs=0` -> `slot_cs` stays 0 for 100 cycles, `ch_ok=0000`.
- Single miss, ch2 addr 0x00123, `OFFS2=0x60000`, `slot_ok` 3 cycles after `slot_cs` -> `slot_addr=0x60123`; `ch_ok[2]` rises 1 cycle after `slot_ok` with `ch_dout[2]=slot_dout`; a repeat of the same address yields no new `slot_cs`.
- All four channels miss at once -> grants 0,1,2,3 in that order. Then new misses on ch0 and ch3 -> grant 0 first, then 3.
- Ch1 changes address 0x10 -> 0x11 during WAIT -> data tagged 0x10 stored, `ch_ok[1]` stays 0, second fetch to 0x11 issued.
- Stale-ok check: `slot_ok` held high across IDLE->ISSUE -> not captured; data captured only from WAIT.
- With `JTFLANE_PCMARB_PREFETCH_EN`: ch0 reads 0x7FFFF then 0x00000 -> prefetch issued for 0x00000 (wrap); `ch_ok[0]` rises 1 cycle after the address change with no `slot_cs`.
